// File: rtl/periph_pkg.sv
// rtl/periph_pkg.sv - shared peripheral addresses and debouncer state type
package periph_pkg;

   // Memory-mapped peripheral addresses seen by the processor
   localparam logic [31:0] SW_ADDR  = 32'hC000_0000;
   localparam logic [31:0] LED_ADDR = 32'hC000_0004;

   // Per-switch debouncer state
   typedef enum logic {DB_STABLE, DB_SETTLING} db_state_t;

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - synchroniser, stability counter and edge pulses for one switch
module debounce_bit
   import periph_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic clean,
   output logic rise,
   output logic fall,
   output logic accept
);

   localparam int              CW       = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   db_state_t              state;
   logic [CW-1:0]          cnt;

   assign s = sync[SYNC_STAGES-1];

   // New level accepted on this edge: it has disagreed with clean for STABLE_CYCLES samples
   assign accept = (state == DB_SETTLING) && (s != clean) && (cnt == CNT_LAST);

   // Plain flip-flop chain into the clock domain, no logic between stages
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], raw};
      end
   end

   // Stability FSM: count consecutive disagreeing samples, drop back on any bounce
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= DB_STABLE;
         cnt   <= '0;
         clean <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= accept & s;
         fall <= accept & ~s;
         case (state)
            DB_STABLE: begin
               if (s != clean) begin
                  state <= DB_SETTLING;
                  cnt   <= CNT_ONE;
               end else begin
                  cnt   <= '0;
               end
            end
            DB_SETTLING: begin
               if (s == clean) begin
                  state <= DB_STABLE;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= DB_STABLE;
                  clean <= s;
                  cnt   <= '0;
               end else begin
                  cnt   <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= DB_STABLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - debounced slide switches with edge pulses and sticky change flags
module switch_debouncer
   import periph_pkg::*;
#(
   parameter int N_SW          = 10,
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 500000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_SW-1:0] sw_raw,
   input  logic [N_SW-1:0] clr_event,
   output logic [N_SW-1:0] sw_clean,
   output logic [N_SW-1:0] sw_rise,
   output logic [N_SW-1:0] sw_fall,
   output logic [N_SW-1:0] sw_event
);

   logic [N_SW-1:0] accept;

   for (genvar i = 0; i < N_SW; i++) begin : g_bit
      debounce_bit #(
         .SYNC_STAGES  (SYNC_STAGES),
         .STABLE_CYCLES(STABLE_CYCLES)
      ) u_bit (
         .clk   (clk),
         .reset (reset),
         .raw   (sw_raw[i]),
         .clean (sw_clean[i]),
         .rise  (sw_rise[i]),
         .fall  (sw_fall[i]),
         .accept(accept[i])
      );
   end

   // Sticky flags rise with the edge pulse; a clear on the same edge loses to the set
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sw_event <= '0;
      end else begin
         sw_event <= (sw_event & ~clr_event) | accept;
      end
   end

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - self-checking bench for switch_debouncer
module tb_switch_debouncer;

   localparam int N      = 10;
   localparam int STABLE = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [N-1:0] sw_raw = '0;
   logic [N-1:0] clr_event = '0;
   logic [N-1:0] sw_clean, sw_rise, sw_fall, sw_event;

   int total = 0;
   int bad   = 0;

   // reference model: last two raw samples, last STABLE synchronised samples
   logic [N-1:0] raw_q[$];
   logic [N-1:0] s_q[$];
   logic [N-1:0] m_clean, m_rise, m_fall, m_event;

   typedef struct {
      logic [N-1:0] raw;
      logic [N-1:0] clr;
      int           n;
      logic [N-1:0] clean;
      logic [N-1:0] rise;
      logic [N-1:0] fall;
      logic [N-1:0] evt;
   } vec_t;

   vec_t tbl[$];

   switch_debouncer #(
      .N_SW         (N),
      .SYNC_STAGES  (2),
      .STABLE_CYCLES(STABLE)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .sw_raw   (sw_raw),
      .clr_event(clr_event),
      .sw_clean (sw_clean),
      .sw_rise  (sw_rise),
      .sw_fall  (sw_fall),
      .sw_event (sw_event)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   task automatic model_clear();
      raw_q.delete();
      s_q.delete();
      m_clean = '0;
      m_rise  = '0;
      m_fall  = '0;
      m_event = '0;
   endtask

   // advance one clock; model the edge from the raw rules, then compare every output
   task automatic tick();
      logic [N-1:0] s_now, acc;
      if (!reset) begin
         model_clear();
      end else begin
         s_now = (raw_q.size() == 2) ? raw_q[0] : '0;
         raw_q.push_back(sw_raw);
         if (raw_q.size() > 2) void'(raw_q.pop_front());
         s_q.push_back(s_now);
         if (s_q.size() > STABLE) void'(s_q.pop_front());
         acc = (s_q.size() == STABLE) ? '1 : '0;
         foreach (s_q[j]) acc &= (s_q[j] ^ m_clean);
         m_rise  = acc & ~m_clean;
         m_fall  = acc & m_clean;
         m_clean = m_clean ^ acc;
         m_event = (m_event & ~clr_event) | acc;
      end
      @(posedge clk);
      #1;
      chk("model_clean", sw_clean, m_clean);
      chk("model_rise",  sw_rise,  m_rise);
      chk("model_fall",  sw_fall,  m_fall);
      chk("model_event", sw_event, m_event);
      chk("rise_fall_excl", sw_rise & sw_fall, '0);
   endtask

   initial begin
      model_clear();

      // 1. reset with all switches high
      tbl.push_back('{10'h3FF, 10'h000, 9, 10'h000, 10'h000, 10'h000, 10'h000});
      tbl.push_back('{10'h3FF, 10'h000, 1, 10'h3FF, 10'h3FF, 10'h000, 10'h3FF});
      tbl.push_back('{10'h3FF, 10'h000, 1, 10'h3FF, 10'h000, 10'h000, 10'h3FF});
      tbl.push_back('{10'h3FF, 10'h3FF, 1, 10'h3FF, 10'h000, 10'h000, 10'h000});
      tbl.push_back('{10'h000, 10'h000, 9, 10'h3FF, 10'h000, 10'h000, 10'h000});
      tbl.push_back('{10'h000, 10'h000, 1, 10'h000, 10'h000, 10'h3FF, 10'h3FF});
      tbl.push_back('{10'h000, 10'h3FF, 1, 10'h000, 10'h000, 10'h000, 10'h000});
      // 2. step on bit 0
      tbl.push_back('{10'h001, 10'h000, 9, 10'h000, 10'h000, 10'h000, 10'h000});
      tbl.push_back('{10'h001, 10'h000, 1, 10'h001, 10'h001, 10'h000, 10'h001});
      tbl.push_back('{10'h001, 10'h000, 1, 10'h001, 10'h000, 10'h000, 10'h001});
      // 3. bounce on bit 3: 5 high, 2 low, 7 high, then low
      tbl.push_back('{10'h009, 10'h000, 5, 10'h001, 10'h000, 10'h000, 10'h001});
      tbl.push_back('{10'h001, 10'h000, 2, 10'h001, 10'h000, 10'h000, 10'h001});
      tbl.push_back('{10'h009, 10'h000, 7, 10'h001, 10'h000, 10'h000, 10'h001});
      tbl.push_back('{10'h001, 10'h000, 12, 10'h001, 10'h000, 10'h000, 10'h001});
      // 4. set bit 5, then clear collides with its fall, then a lone clear
      tbl.push_back('{10'h021, 10'h000, 9, 10'h001, 10'h000, 10'h000, 10'h001});
      tbl.push_back('{10'h021, 10'h000, 1, 10'h021, 10'h020, 10'h000, 10'h021});
      tbl.push_back('{10'h001, 10'h000, 9, 10'h021, 10'h000, 10'h000, 10'h021});
      tbl.push_back('{10'h001, 10'h020, 1, 10'h001, 10'h000, 10'h020, 10'h021});
      tbl.push_back('{10'h001, 10'h020, 1, 10'h001, 10'h000, 10'h000, 10'h001});
      tbl.push_back('{10'h001, 10'h000, 1, 10'h001, 10'h000, 10'h000, 10'h001});

      // reset held low with switches high: everything stays at zero
      sw_raw = 10'h3FF;
      #3;
      chk("rst_clean", sw_clean, '0);
      chk("rst_rise",  sw_rise,  '0);
      chk("rst_fall",  sw_fall,  '0);
      chk("rst_event", sw_event, '0);
      tick();
      tick();
      reset = 1'b1;

      foreach (tbl[k]) begin
         sw_raw    = tbl[k].raw;
         clr_event = tbl[k].clr;
         for (int c = 0; c < tbl[k].n; c++) tick();
         chk($sformatf("vec%0d_clean", k), sw_clean, tbl[k].clean);
         chk($sformatf("vec%0d_rise",  k), sw_rise,  tbl[k].rise);
         chk($sformatf("vec%0d_fall",  k), sw_fall,  tbl[k].fall);
         chk($sformatf("vec%0d_event", k), sw_event, tbl[k].evt);
      end
      clr_event = '0;

      // 5. reset four cycles into the settling of bit 7
      sw_raw = 10'h081;
      for (int c = 0; c < 6; c++) tick();
      chk("mid_settle_clean", sw_clean, 10'h001);
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_clean", sw_clean, '0);
      chk("midrst_rise",  sw_rise,  '0);
      chk("midrst_event", sw_event, '0);
      tick();
      tick();
      reset = 1'b1;
      for (int c = 0; c < 9; c++) tick();
      chk("relat_clean_early", sw_clean, '0);
      tick();
      chk("relat_clean", sw_clean, 10'h081);
      chk("relat_rise",  sw_rise,  10'h081);
      tick();
      chk("relat_rise_end", sw_rise, '0);

      // 6. random per-bit toggles with random clears
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 5) == 0) sw_raw[b] = ~sw_raw[b];
            clr_event[b] = ($urandom_range(0, 7) == 0);
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
